// File: rtl/clkdiv_seq_pkg.sv
// Shared constants for the CLKDIV/OSER10 startup sequencer: one-hot state
// encodings and default timing values.
package clkdiv_seq_pkg;

  localparam int STATE_W = 6;

  localparam logic [STATE_W-1:0] ST_WAIT_LOCK   = 6'b000001;
  localparam logic [STATE_W-1:0] ST_DIV_RST     = 6'b000010;
  localparam logic [STATE_W-1:0] ST_DIV_SETTLE  = 6'b000100;
  localparam logic [STATE_W-1:0] ST_RUN         = 6'b001000;
  localparam logic [STATE_W-1:0] ST_CALIB_PULSE = 6'b010000;
  localparam logic [STATE_W-1:0] ST_CALIB_GAP   = 6'b100000;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 32;
  localparam int DEF_CALIB_GAP     = 64;
  localparam int DEF_CNT_W         = 8;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/clkdiv_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/clkdiv_seq_ctrl.sv
// Startup/realignment sequencer for CLKDIV and the OSER10 serializers it clocks:
// waits for PLL lock, sequences divider and serializer resets, and issues CALIB pulses.
module clkdiv_seq_ctrl
  import clkdiv_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CALIB_GAP     = DEF_CALIB_GAP,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  hclkin,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  realign_req,
  input  logic                  calib_req,
  output logic                  clkdiv_resetn,
  output logic                  clkdiv_calib,
  output logic                  ser_reset,
  output logic                  ready,
  output logic                  calib_busy,
  output logic                  calib_done,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_N = (RST_CYCLES > SETTLE_CYCLES)
                         ? ((RST_CYCLES > CALIB_GAP) ? RST_CYCLES : CALIB_GAP)
                         : ((SETTLE_CYCLES > CALIB_GAP) ? SETTLE_CYCLES : CALIB_GAP);

  if ((MAX_N - 1) > ((2 ** CNT_W) - 1)) begin : g_cnt_w_too_small
    $error("CNT_W too small for the largest timed state length");
  end
  if (RST_CYCLES < 2 || SETTLE_CYCLES < 1 || CALIB_GAP < 1) begin : g_bad_timing
    $error("Timing parameters out of range");
  end

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(CALIB_GAP - 1);

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

  logic                lock_s;
  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  nxt_state;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_zero;
  logic                lock_lost;

  sync_2ff u_lock_sync (
    .clk   (hclkin),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign cnt_zero  = (cnt == '0);
  assign lock_lost = !lock_s && (state != ST_WAIT_LOCK);

  // Next-state: lock loss dominates, then realign, then calib requests.
  always_comb begin
    nxt_state = state;
    if (!lock_s) begin
      nxt_state = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_WAIT_LOCK:   nxt_state = ST_DIV_RST;
        ST_DIV_RST:     if (cnt_zero) nxt_state = ST_DIV_SETTLE;
        ST_DIV_SETTLE:  if (cnt_zero) nxt_state = ST_RUN;
        ST_RUN: begin
          if (realign_req)    nxt_state = ST_DIV_RST;
          else if (calib_req) nxt_state = ST_CALIB_PULSE;
        end
        ST_CALIB_PULSE: nxt_state = realign_req ? ST_DIV_RST : ST_CALIB_GAP;
        ST_CALIB_GAP: begin
          if (realign_req)   nxt_state = ST_DIV_RST;
          else if (cnt_zero) nxt_state = ST_RUN;
        end
        default:        nxt_state = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_WAIT_LOCK;
      cnt           <= '0;
      calib_done    <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= nxt_state;
      calib_done <= (state == ST_CALIB_GAP) && (nxt_state == ST_RUN);
      if (lock_lost) lock_loss_cnt <= sat_inc(lock_loss_cnt);
      // Timed states load N-1 on entry and leave once the count hits zero.
      if (nxt_state != state) begin
        case (nxt_state)
          ST_DIV_RST:    cnt <= RST_LOAD;
          ST_DIV_SETTLE: cnt <= SETTLE_LOAD;
          ST_CALIB_GAP:  cnt <= GAP_LOAD;
          default:       cnt <= '0;
        endcase
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign clkdiv_resetn = ~|(state & (ST_WAIT_LOCK | ST_DIV_RST));
  assign ser_reset     =  |(state & (ST_WAIT_LOCK | ST_DIV_RST | ST_DIV_SETTLE));
  assign ready         =  |(state & (ST_RUN | ST_CALIB_PULSE | ST_CALIB_GAP));
  assign clkdiv_calib  =  |(state & ST_CALIB_PULSE);
  assign calib_busy    =  |(state & (ST_CALIB_PULSE | ST_CALIB_GAP));

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Directed bench for clkdiv_seq_ctrl with default timing (16/32/64).
module tb_clkdiv_seq_ctrl;

  logic       hclkin = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       realign_req;
  logic       calib_req;
  logic       clkdiv_resetn;
  logic       clkdiv_calib;
  logic       ser_reset;
  logic       ready;
  logic       calib_busy;
  logic       calib_done;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  clkdiv_seq_ctrl dut (
    .hclkin        (hclkin),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .realign_req   (realign_req),
    .calib_req     (calib_req),
    .clkdiv_resetn (clkdiv_resetn),
    .clkdiv_calib  (clkdiv_calib),
    .ser_reset     (ser_reset),
    .ready         (ready),
    .calib_busy    (calib_busy),
    .calib_done    (calib_done),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 hclkin = ~hclkin;

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge hclkin);
    #1;
    cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_clkdiv_resetn"}, clkdiv_resetn, 0);
    check_eq({tag, "_clkdiv_calib"},  clkdiv_calib,  0);
    check_eq({tag, "_ser_reset"},     ser_reset,     1);
    check_eq({tag, "_ready"},         ready,         0);
    check_eq({tag, "_calib_busy"},    calib_busy,    0);
    check_eq({tag, "_calib_done"},    calib_done,    0);
    check_eq({tag, "_lock_loss_cnt"}, lock_loss_cnt, 0);
  endtask

  // Edge e counts from the first edge at which pll_lock is seen high.
  task automatic run_startup(input string tag);
    for (int e = 1; e <= 52; e++) begin
      step();
      check_eq({tag, "_clkdiv_resetn"}, clkdiv_resetn, (e >= 19) ? 1 : 0);
      check_eq({tag, "_ready"},         ready,         (e >= 51) ? 1 : 0);
      check_eq({tag, "_ser_reset"},     ser_reset,     (e >= 51) ? 0 : 1);
      check_eq({tag, "_clkdiv_calib"},  clkdiv_calib,  0);
    end
  endtask

  initial begin
    int busy_cnt, calib_cnt, done_cnt, done_at, gap, lo, rdy_at, bad;
    resetn = 1'b0; pll_lock = 1'b1; realign_req = 1'b0; calib_req = 1'b0;

    // Reset values with lock already high
    repeat (3) step();
    check_reset_vals("rst");
    resetn = 1'b1;
    run_startup("start_locked");

    // Lock arrives late
    resetn = 1'b0; pll_lock = 1'b0;
    step();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (clkdiv_resetn !== 1'b0 || ready !== 1'b0) bad++;
    end
    check_eq("late_lock_held", bad, 0);
    pll_lock = 1'b1;
    run_startup("late_lock");

    // Single CALIB request
    check_eq("lost_before_calib", lock_loss_cnt, 0);
    calib_req = 1'b1;
    step();
    calib_req = 1'b0;
    check_eq("calib_pulse", clkdiv_calib, 1);
    check_eq("calib_busy0", calib_busy, 1);
    busy_cnt = 1; calib_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      busy_cnt  += int'(calib_busy);
      calib_cnt += int'(clkdiv_calib);
      if (calib_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check_eq("calib_busy_len", busy_cnt, 65);
    check_eq("calib_single", calib_cnt, 0);
    check_eq("calib_done_cnt", done_cnt, 1);
    check_eq("calib_done_at", done_at, 65);
    check_eq("calib_ready", ready, 1);

    // Held request: count idle cycles between consecutive pulses
    calib_req = 1'b1;
    step();
    check_eq("held_pulse1", clkdiv_calib, 1);
    gap = 0;
    step();
    while (clkdiv_calib !== 1'b1 && gap < 200) begin
      gap++;
      step();
    end
    calib_req = 1'b0;
    check_eq("held_gap", gap, 65);
    repeat (70) step();
    check_eq("held_back_run", calib_busy, 0);

    // Realign from RUN
    realign_req = 1'b1;
    step();
    realign_req = 1'b0;
    check_eq("realign_ready_drop", ready, 0);
    lo = int'(!clkdiv_resetn); rdy_at = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (!clkdiv_resetn) lo++;
      if (ready && rdy_at == 0) rdy_at = k;
    end
    check_eq("realign_rst_len", lo, 16);
    check_eq("realign_ready_at", rdy_at, 48);
    check_eq("realign_no_loss", lock_loss_cnt, 0);

    // Lock loss during CALIB_GAP
    calib_req = 1'b1;
    step();
    calib_req = 1'b0;
    repeat (10) step();
    check_eq("gap_busy", calib_busy, 1);
    pll_lock = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      done_cnt += int'(calib_done);
    end
    check_eq("loss_ready", ready, 0);
    check_eq("loss_clkdiv_resetn", clkdiv_resetn, 0);
    check_eq("loss_ser_reset", ser_reset, 1);
    check_eq("loss_cnt1", lock_loss_cnt, 1);
    check_eq("loss_no_done", done_cnt, 0);
    check_eq("loss_busy", calib_busy, 0);

    // Repeated lock loss: each lap enters DIV_RST then drops lock
    for (int lap = 1; lap <= 300; lap++) begin
      pll_lock = 1'b1;
      repeat (3) step();
      pll_lock = 1'b0;
      repeat (3) step();
      if (lap == 100) check_eq("loss_cnt101", lock_loss_cnt, 101);
      if (lap == 254) check_eq("loss_cnt255", lock_loss_cnt, 255);
    end
    check_eq("loss_cnt_sat", lock_loss_cnt, 255);

    // Asynchronous reset in DIV_SETTLE
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    pll_lock = 1'b1;
    repeat (24) step();
    check_eq("settle_clkdiv_resetn", clkdiv_resetn, 1);
    check_eq("settle_ser_reset", ser_reset, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    step();
    resetn = 1'b1;
    run_startup("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
